// File: rtl/cordic_feeder_pkg.sv
// Shared types and helpers for the CORDIC magnitude/phase feeder.
package cordic_feeder_pkg;

  // Sequencer states: idle, waiting on the core, holding a finished result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Address width for a FIFO of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cordic_sample_fifo.sv
// Small synchronous FIFO holding packed {x, y} samples. The head entry is
// visible combinationally so the core inputs can be driven straight from it.
module cordic_sample_fifo
  import cordic_feeder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Refuse writes when full and reads when empty, whatever the caller asks.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Sample storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
    end
  end

  // Read/write pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/cordic_mag_ph_feeder.sv
// Streaming wrapper for the serial magnitude/phase CORDIC core: buffers I/Q
// samples, issues one start per sample, and parks each result in an output
// register with a valid/ready handshake.
module cordic_mag_ph_feeder
  import cordic_feeder_pkg::*;
#(
  parameter int XY_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XY_WIDTH-1:0] in_x,
  input  logic [XY_WIDTH-1:0] in_y,
  output logic                core_st,
  output logic [XY_WIDTH-1:0] core_xin,
  output logic [XY_WIDTH-1:0] core_yin,
  input  logic                core_rdy,
  input  logic [XY_WIDTH-1:0] core_mag,
  input  logic [XY_WIDTH+1:0] core_ph,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XY_WIDTH-1:0] out_mag,
  output logic [XY_WIDTH+1:0] out_ph,
  output logic                busy
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [2*XY_WIDTH-1:0]   w_head;
  logic                    w_push;
  logic                    w_start;
  logic                    w_capture;
  logic                    w_out_free;
  logic                    r_out_valid;
  logic [XY_WIDTH-1:0]     r_out_mag;
  logic [XY_WIDTH+1:0]     r_out_ph;

  // in_ready depends only on registered FIFO state: no push-through when full.
  assign in_ready = ~w_fifo_full;
  assign w_push   = in_valid & ~w_fifo_full;

  cordic_sample_fifo #(
    .WIDTH (2 * XY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_start),
    .i_wdata ({in_x, in_y}),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // The output register can take a result if empty or emptying this cycle.
  assign w_out_free = ~r_out_valid | out_ready;

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Sequencer transitions: one sample in flight in the core at a time.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (!w_fifo_empty) w_state_next = WAIT;
      WAIT: if (core_rdy)      w_state_next = w_out_free ? IDLE : HOLD;
      HOLD: if (w_out_free)    w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // Sequencer outputs: start pulse (also pops the FIFO) and result capture.
  always_comb begin
    w_start   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE:    w_start   = ~w_fifo_empty;
      WAIT:    w_capture = core_rdy & w_out_free;
      HOLD:    w_capture = w_out_free;
      default: ;
    endcase
  end

  // Output register: load on capture, otherwise clear valid once accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_mag   <= '0;
      r_out_ph    <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_mag   <= core_mag;
      r_out_ph    <= core_ph;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign core_st   = w_start;
  assign core_xin  = w_head[2*XY_WIDTH-1:XY_WIDTH];
  assign core_yin  = w_head[XY_WIDTH-1:0];
  assign out_valid = r_out_valid;
  assign out_mag   = r_out_mag;
  assign out_ph    = r_out_ph;
  assign busy      = (r_state != IDLE) | ~w_fifo_empty;

endmodule

// File: tb/tb_cordic_mag_ph_feeder.sv
// Bench for cordic_mag_ph_feeder with a behavioural stand-in for the serial
// CORDIC core and a queue-based scoreboard on the output stream.
module tb_cordic_mag_ph_feeder;

  localparam int XW    = 16;
  localparam int DEPTH = 4;
  localparam int N     = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_x = '0;
  logic [XW-1:0] in_y = '0;
  logic          core_st;
  logic [XW-1:0] core_xin;
  logic [XW-1:0] core_yin;
  logic          core_rdy;
  logic [XW-1:0] core_mag;
  logic [XW+1:0] core_ph;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [XW-1:0] out_mag;
  logic [XW+1:0] out_ph;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_started = 0;
  int n_delivered = 0;
  int n_accepted = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  cordic_mag_ph_feeder #(
    .XY_WIDTH   (XW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .core_st   (core_st),
    .core_xin  (core_xin),
    .core_yin  (core_yin),
    .core_rdy  (core_rdy),
    .core_mag  (core_mag),
    .core_ph   (core_ph),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_ph    (out_ph),
    .busy      (busy)
  );

  // Ideal magnitude/phase of a Q1.15 sample; phase scaled so pi = 2^16.
  function automatic logic [33:0] ref_res(input logic [15:0] x, input logic [15:0] y);
    real rx, ry, m, p;
    int  mi, pv;
    rx = $itor($signed(x));
    ry = $itor($signed(y));
    m  = $sqrt(rx * rx + ry * ry);
    p  = $atan2(ry, rx) * 65536.0 / 3.14159265358979;
    mi = $rtoi($floor(m + 0.5));
    pv = $rtoi($floor(p + 0.5));
    return {mi[15:0], pv[17:0]};
  endfunction

  // Core stand-in: N+2 clocks per sample (2 when y=0), result held while idle.
  int          m_cnt;
  logic [33:0] m_res;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_rdy <= 1'b0;
      m_cnt    <= 0;
      m_res    <= '0;
      core_mag <= '0;
      core_ph  <= '0;
    end else if (core_st) begin
      core_rdy <= 1'b0;
      m_cnt    <= (core_yin == '0) ? 1 : N + 1;
      m_res    <= ref_res(core_xin, core_yin);
    end else if (m_cnt == 1) begin
      core_rdy <= 1'b1;
      m_cnt    <= 0;
      core_mag <= m_res[33:18];
      core_ph  <= m_res[17:0];
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h +/-%0d", name, act, exp, tol);
    end
  endtask

  // Input side of the scoreboard: every accepted sample predicts one result.
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) begin
      exp_q.push_back(ref_res(in_x, in_y));
      n_accepted++;
      $display("IN  x=%04h y=%04h", in_x, in_y);
    end
  end

  // Output monitor: protocol checks on starts, hold stability, result order.
  logic        prev_st = 1'b0;
  logic        stall_prev = 1'b0;
  logic [33:0] held = '0;
  logic [33:0] exp_e;
  always @(negedge clk) begin
    if (!reset) begin
      if (core_st) begin
        chk("st_back_to_back", prev_st, 0);
        chk("st_while_busy", n_started - n_delivered - int'(out_valid), 0);
        n_started++;
      end
      prev_st = core_st;
      if (stall_prev) begin
        chk("out_valid_held", out_valid, 1);
        chk("out_data_held", {out_mag, out_ph}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got mag=%04h ph=%05h expected none", out_mag, out_ph);
        end else begin
          exp_e = exp_q.pop_front();
          chk("out_mag", out_mag, exp_e[33:18]);
          chk("out_ph", out_ph, exp_e[17:0]);
          $display("OUT mag=%04h ph=%05h exp_mag=%04h exp_ph=%05h",
                   out_mag, out_ph, exp_e[33:18], exp_e[17:0]);
        end
        n_delivered++;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_mag, out_ph};
    end else begin
      prev_st = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_core_st"}, core_st, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_mag"}, out_mag, 0);
    chk({tag, "_out_ph"}, out_ph, 0);
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (!busy && !out_valid) begin
        done = 1;
        break;
      end
    end
    chk("idle_reached", done, 1);
  endtask

  // Push one sample into an idle block and time the start and the result.
  task automatic single(input logic [15:0] x, input logic [15:0] y,
                        input int exp_st, input int exp_ov,
                        input int emag, input int eph, input int tol_m, input int tol_p);
    int st_c = -1;
    int ov_c = -1;
    @(posedge clk); #1;
    in_x = x; in_y = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (core_st && st_c < 0) st_c = c;
      if (out_valid) begin
        ov_c = c;
        break;
      end
    end
    chk("start_cycle", st_c, exp_st);
    chk("valid_cycle", ov_c, exp_ov);
    chk_tol("single_mag", int'(out_mag), emag, tol_m);
    chk_tol("single_ph", int'($signed(out_ph)), eph, tol_p);
    $display("SINGLE x=%04h y=%04h start@%0d valid@%0d mag=%04h ph=%05h",
             x, y, st_c, ov_c, out_mag, out_ph);
    wait_idle(100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first_drop, s0, sent, cyc;
    bit w;

    // Reset values, during and after reset.
    #1;
    check_reset_vals("in_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    // Directed values and latencies.
    single(16'h4000, 16'h0000, 1, 4, 16'h4000, 0, 0, 0);
    single(16'hC000, 16'h0000, 1, 4, 16'h4000, 32'h10000, 0, 0);
    single(16'h2000, 16'h2000, 1, N + 4, 16'h2D41, 32'h04000, 4, 2);

    // Back-pressure: six samples with the consumer stalled.
    s0 = n_started;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_x = 16'($urandom); in_y = 16'($urandom) | 16'h0001; in_valid = 1'b1;
    acc = 0; first_drop = -1;
    for (int k = 0; k < 200 && acc < 6; k++) begin
      @(negedge clk);
      w = in_ready;
      if (!w && first_drop < 0) first_drop = acc;
      @(posedge clk); #1;
      if (w) begin
        acc++;
        if (acc < 6) begin
          in_x = 16'($urandom); in_y = 16'($urandom) | 16'h0001;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("accepted_before_full", first_drop, 5);
    chk("accepted_total", acc, 6);
    repeat (40) @(negedge clk);
    chk("starts_while_stalled", n_started - s0, 2);
    chk("full_while_holding", in_ready, 0);
    chk("valid_while_stalled", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(400);
    chk("drain_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a calculation with three samples queued.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      in_x = 16'($urandom); in_y = 16'($urandom) | 16'h0001; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_before_reset", busy, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    exp_q.delete();
    n_started = 0;
    n_delivered = 0;
    n_accepted = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_mid_reset");
    single(16'h4000, 16'h0000, 1, 4, 16'h4000, 0, 0, 0);

    // Random traffic on both handshakes.
    sent = 0; cyc = 0;
    @(posedge clk); #1;
    while (sent < 1000 && cyc < 40000) begin
      if (!in_valid && ($urandom % 4) != 0) begin
        in_valid = 1'b1;
        in_x = 16'($urandom);
        in_y = (($urandom % 8) == 0) ? 16'h0000 : 16'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      w = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (w) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("random_sent", sent, 1000);
    wait_idle(400);
    chk("random_queue_empty", exp_q.size(), 0);
    chk("random_delivered", n_delivered, n_accepted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_mag_ph_feeder.md
# cordic_mag_ph_feeder

Streaming front/back end for the serial magnitude/phase CORDIC core. It accepts I/Q samples on a valid/ready input and buffers them in a small FIFO. It issues one start pulse per sample to the core, waits for the core's level-type ready, and presents the captured magnitude/phase on a valid/ready output. It sits between the sample source (mixer/decimator) and magnitude/phase consumers, and turns the core's start/ready protocol into standard streaming handshakes.

## Interface
- XY_WIDTH, 16, width of I/Q samples and magnitude; phase is XY_WIDTH+2
- FIFO_DEPTH, 4, input FIFO entries; power of 2, ≥2
- Reset is asynchronous and active-high on `reset`; clock is `clk`.
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  FIFO not full
- in_x, in_y  in  XY_WIDTH each  signed I/Q, range [-1, 1)
- core_st  out  1  start pulse to core, one cycle per sample
- core_xin, core_yin  out  XY_WIDTH each  FIFO head sample
- core_rdy  in  1  core result-ready level
- core_mag  in  XY_WIDTH  core magnitude, unsigned
- core_ph  in  XY_WIDTH+2  core phase, signed; pi = 01 followed by zeros
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts
- out_mag  out  XY_WIDTH  registered magnitude
- out_ph  out  XY_WIDTH+2  registered phase
- busy  out  1  high when state ≠ IDLE or FIFO non-empty

## Operation
- Input push: in_valid & in_ready writes {in_x, in_y} to the FIFO tail.
  - in_ready = !full, registered-state-derived only; no push-through on a simultaneous pop while full.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, core_st=1 (combinational) and core_xin/core_yin=head; pop the head; go to WAIT. Otherwise core_st=0.
  - WAIT: core_rdy is guaranteed low from the cycle after the start pulse. When core_rdy=1:
    - if the output register is free (out_valid=0, or out_valid & out_ready this cycle), load out_mag←core_mag, out_ph←core_ph, set out_valid, go to IDLE;
    - otherwise go to HOLD.
  - HOLD: the core holds mag/ph stable while idle. Capture as soon as the output register frees, then go to IDLE.
- A new start is never issued while in WAIT or HOLD, so the core is never restarted mid-calculation and its result is never overwritten.
- A start may be issued while out_valid is still pending. The next result waits in HOLD.
- Output: out_valid stays high with out_mag/out_ph stable until out_ready. Data passes unmodified, with no width conversion.
- core_xin/core_yin are driven from the FIFO head at all times and are only meaningful when core_st=1.
- Reset: asynchronous and shared with the core. FSM→IDLE, FIFO emptied (pointers 0), out_valid=0, out_mag=0, out_ph=0, core_st=0, busy=0, in_ready=1 after reset release.
  - Reset mid-calculation discards all buffered and in-flight samples.

## Timing
- Sample accepted at cycle 0 into an empty FIFO with the FSM in IDLE:
  - core_st=1 in cycle 1;
  - core_rdy rises in cycle N+3 (core needs N+2 clocks), or in cycle 3 when y=0;
  - out_valid=1 in cycle N+4, or in cycle 4 when y=0.
- Throughput is one sample per N+3 cycles with out_ready held high: IDLE cycle + core latency + capture.
- core_st is never high on two consecutive cycles.

## Structure
- Package cordic_feeder_pkg holds the state enum typedef (IDLE, WAIT, HOLD) and the FIFO pointer-width function.
- Sub-module cordic_sample_fifo: synchronous FIFO, 2·XY_WIDTH wide, FIFO_DEPTH deep, with full/empty flags and an async reset.
- The core is instantiated beside this block at the parent level, not inside it.

## Test plan
All scenarios use N=8 and XY_WIDTH=16, with the feeder wired to the serial core.
- Push x=0x4000, y=0 into an idle block → core_st in cycle 1; out_valid in cycle 4 with out_mag=0x4000, out_ph=0.
- Push x=0xC000, y=0 → out_ph=0x10000 (pi), out_mag=0x4000.
- Push x=y=0x2000 → out_valid in cycle 12; out_ph=0x04000 ±2 LSB; out_mag=0x2D41 ±4 LSB.
- Push 6 samples back-to-back with out_ready=0:
  - in_ready drops after 5 accepted (4 in FIFO + 1 in core);
  - the second result waits in HOLD;
  - releasing out_ready drains all 6 in order, values matching the reference model.
- Assert reset in cycle 5 of a calculation with 3 samples queued → all outputs return to reset values immediately. A fresh sample then completes with normal latency and no stale output.
- Random in_valid/out_ready over 1000 samples → no loss or duplication; core_st never asserted in WAIT/HOLD; results match the model.
